// File: rtl/ula_pkg.sv
// Shared opcode encoding for the ULA and a small opcode classification helper.
package ula_pkg;

  typedef enum logic [4:0] {
    OP_ADD        = 5'b00000,
    OP_ADDINC     = 5'b00001,
    OP_INCA       = 5'b00011,
    OP_SUBDEC     = 5'b00100,
    OP_SUB        = 5'b00101,
    OP_DECA       = 5'b00110,
    OP_LSL        = 5'b01000,
    OP_ASR        = 5'b01001,
    OP_ZERO       = 5'b10000,
    OP_AND        = 5'b10001,
    OP_NOTA_AND_B = 5'b10010,
    OP_B          = 5'b10011,
    OP_A_AND_NOTB = 5'b10100,
    OP_A          = 5'b10101,
    OP_XOR        = 5'b10110,
    OP_OR         = 5'b10111,
    OP_NOR        = 5'b11000,
    OP_XNOR       = 5'b11001,
    OP_NOTA       = 5'b11010,
    OP_NOTA_OR_B  = 5'b11011,
    OP_NOTB       = 5'b11100,
    OP_A_OR_NOTB  = 5'b11101,
    OP_NAND       = 5'b11110,
    OP_ONE        = 5'b11111
  } opcode_t;

  // Arithmetic opcodes are exactly the ones routed through the shared adder.
  function automatic logic op_is_arith(input opcode_t op);
    case (op)
      OP_ADD, OP_ADDINC, OP_INCA, OP_SUBDEC, OP_SUB, OP_DECA: op_is_arith = 1'b1;
      default:                                                op_is_arith = 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/ula_addsub.sv
// Shared WIDTH-bit adder with carry-in and carry-out; all ULA arithmetic goes through here.
module ula_addsub #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic [WIDTH-1:0] sum,
  output logic             cout
);

  assign {cout, sum} = {1'b0, a} + {1'b0, b} + {{WIDTH{1'b0}}, cin};

endmodule

// File: rtl/ula.sv
// ULA: one-cycle registered arithmetic/logic unit; Out/Flag are the only state.
// Optional macro ULA_SHIFT_EN enables the LSL/ASR opcodes, otherwise they yield zero.
module ula
  import ula_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic [4:0]       opcode,
  output logic [WIDTH-1:0] Out,
  output logic             Flag
);

  opcode_t          op;
  logic [WIDTH-1:0] add_b;
  logic             add_cin;
  logic [WIDTH-1:0] add_sum;
  logic             add_cout;
  logic [WIDTH-1:0] res;
  logic             flg;

  assign op = opcode_t'(opcode);

  // Subtraction is A + ~B (+1); inc/dec reuse the adder with a constant B operand.
  always_comb begin
    add_b   = B;
    add_cin = 1'b0;
    case (op)
      OP_ADDINC: add_cin = 1'b1;
      OP_INCA: begin
        add_b   = '0;
        add_cin = 1'b1;
      end
      OP_SUBDEC: add_b = ~B;
      OP_SUB: begin
        add_b   = ~B;
        add_cin = 1'b1;
      end
      OP_DECA: add_b = '1;
      default: ;
    endcase
  end

  ula_addsub #(.WIDTH(WIDTH)) u_addsub (
    .a    (A),
    .b    (add_b),
    .cin  (add_cin),
    .sum  (add_sum),
    .cout (add_cout)
  );

  always_comb begin
    res = '0;
    flg = 1'b0;
    if (op_is_arith(op)) begin
      res = add_sum;
      flg = add_cout;
    end else begin
      case (op)
`ifdef ULA_SHIFT_EN
        OP_LSL: begin
          res = {A[WIDTH-2:0], 1'b0};
          flg = A[WIDTH-1];
        end
        OP_ASR: begin
          res = {A[WIDTH-1], A[WIDTH-1:1]};
          flg = A[0];
        end
`else
        OP_LSL, OP_ASR: ;
`endif
        OP_ZERO:       res = '0;
        OP_AND:        res = A & B;
        OP_NOTA_AND_B: res = ~A & B;
        OP_B:          res = B;
        OP_A_AND_NOTB: res = A & ~B;
        OP_A:          res = A;
        OP_XOR:        res = A ^ B;
        OP_OR:         res = A | B;
        OP_NOR:        res = ~(A | B);
        OP_XNOR:       res = ~(A ^ B);
        OP_NOTA:       res = ~A;
        OP_NOTA_OR_B:  res = ~A | B;
        OP_NOTB:       res = ~B;
        OP_A_OR_NOTB:  res = A | ~B;
        OP_NAND:       res = ~(A & B);
        OP_ONE:        res = {{(WIDTH-1){1'b0}}, 1'b1};
        default:       ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      Out  <= '0;
      Flag <= 1'b0;
    end else begin
      Out  <= res;
      Flag <= flg;
    end
  end

endmodule

// File: tb/tb_ula.sv
// Self-checking bench for ula (WIDTH=32): directed vectors, reset behaviour and randomized ops vs a reference model.
module tb_ula;

  localparam int W = 32;

  logic          clk;
  logic          rst_n;
  logic [W-1:0]  A;
  logic [W-1:0]  B;
  logic [4:0]    opcode;
  logic [W-1:0]  Out;
  logic          Flag;

  int checks   = 0;
  int failures = 0;

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic [4:0]  op;
    logic [31:0] eo;
    logic        ef;
  } vec_t;

  ula #(.WIDTH(W)) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .A      (A),
    .B      (B),
    .opcode (opcode),
    .Out    (Out),
    .Flag   (Flag)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: plain integer arithmetic on a 64-bit accumulator; Flag is "sum reached 2^32".
  function automatic void model(input logic [31:0] a, input logic [31:0] b, input logic [4:0] op,
                                output logic [31:0] o, output logic f);
    longint unsigned s;
    longint unsigned m;
    m = 64'd4294967296;
    s = 0;
    o = '0;
    f = 1'b0;
    case (op)
      5'd0:  s = 64'(a) + 64'(b);
      5'd1:  s = 64'(a) + 64'(b) + 1;
      5'd3:  s = 64'(a) + 1;
      5'd4:  s = 64'(a) + (m - 1 - 64'(b));
      5'd5:  s = 64'(a) + (m - 64'(b));
      5'd6:  s = 64'(a) + (m - 1);
`ifdef ULA_SHIFT_EN
      5'd8: begin
        o = 32'((64'(a) * 2) % m);
        f = a[31];
      end
      5'd9: begin
        o = (a >> 1) | (a[31] ? 32'h8000_0000 : 32'h0);
        f = a[0];
      end
`endif
      5'd16: o = 32'h0;
      5'd17: o = a & b;
      5'd18: o = ~a & b;
      5'd19: o = b;
      5'd20: o = a & ~b;
      5'd21: o = a;
      5'd22: o = a ^ b;
      5'd23: o = a | b;
      5'd24: o = ~(a | b);
      5'd25: o = ~(a ^ b);
      5'd26: o = ~a;
      5'd27: o = ~a | b;
      5'd28: o = ~b;
      5'd29: o = a | ~b;
      5'd30: o = ~(a & b);
      5'd31: o = 32'h1;
      default: ;
    endcase
    if (op inside {5'd0, 5'd1, 5'd3, 5'd4, 5'd5, 5'd6}) begin
      o = 32'(s % m);
      f = (s >= m);
    end
  endfunction

  task automatic test_reset();
    rst_n = 1'b1;
    A = 32'h1234_5678; B = 32'h1; opcode = 5'b00000;
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if ({Out, Flag} !== {32'h0, 1'b0}) begin
      failures++;
      $display("FAIL reset_assert got Out=%h Flag=%b expected Out=00000000 Flag=0", Out, Flag);
    end
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if ({Out, Flag} !== {32'h0, 1'b0}) begin
      failures++;
      $display("FAIL reset_hold got Out=%h Flag=%b expected Out=00000000 Flag=0", Out, Flag);
    end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_directed();
    vec_t v[$];
    v.push_back('{32'h1,          32'h2,          5'b00000, 32'h3,          1'b0});
    v.push_back('{32'hFFFF_FFFF,  32'h1,          5'b00000, 32'h0,          1'b1});
    v.push_back('{32'h1,          32'h1,          5'b00001, 32'h3,          1'b0});
    v.push_back('{32'h5,          32'h1,          5'b00100, 32'h3,          1'b1});
    v.push_back('{32'h5,          32'h4,          5'b00101, 32'h1,          1'b1});
    v.push_back('{32'h5,          32'h0,          5'b00110, 32'h4,          1'b1});
    v.push_back('{32'h0,          32'h1,          5'b00101, 32'hFFFF_FFFF,  1'b0});
    v.push_back('{32'hFFFF_FFFF,  32'h0,          5'b00011, 32'h0,          1'b1});
    v.push_back('{32'h8000_0002,  32'hFFFF_FFFE,  5'b11001, 32'h8000_0003,  1'b0});
    v.push_back('{32'h8000_0002,  32'hFFFF_FFFE,  5'b11010, 32'h7FFF_FFFD,  1'b0});
    v.push_back('{32'h8000_0002,  32'hFFFF_FFFE,  5'b11101, 32'h8000_0003,  1'b0});
    v.push_back('{32'h8000_0002,  32'hFFFF_FFFE,  5'b11110, 32'h7FFF_FFFD,  1'b0});
    v.push_back('{32'h8000_0002,  32'hFFFF_FFFE,  5'b11111, 32'h0000_0001,  1'b0});
    v.push_back('{32'h2,          32'hFFFF_FFFE,  5'b11000, 32'h1,          1'b0});
    v.push_back('{32'h2,          32'hFFFF_FFFE,  5'b10110, 32'hFFFF_FFFC,  1'b0});
    v.push_back('{32'hFFFF_FFFF,  32'hFFFF_FFFF,  5'b00010, 32'h0,          1'b0});
    foreach (v[i]) begin
      A = v[i].a; B = v[i].b; opcode = v[i].op;
      @(posedge clk);
      #1;
      checks++;
      if ({Out, Flag} !== {v[i].eo, v[i].ef}) begin
        failures++;
        $display("FAIL directed[%0d] op=%b got Out=%h Flag=%b expected Out=%h Flag=%b",
                 i, v[i].op, Out, Flag, v[i].eo, v[i].ef);
      end
    end
  endtask

  task automatic test_shift();
    vec_t v[$];
`ifdef ULA_SHIFT_EN
    v.push_back('{32'h5,         32'h0, 5'b01000, 32'hA,         1'b0});
    v.push_back('{32'h8000_0005, 32'h0, 5'b01001, 32'hC000_0002, 1'b1});
    v.push_back('{32'h8000_0000, 32'h0, 5'b01000, 32'h0,         1'b1});
`else
    v.push_back('{32'h5,         32'h0, 5'b01000, 32'h0,         1'b0});
    v.push_back('{32'h8000_0005, 32'h0, 5'b01001, 32'h0,         1'b0});
    v.push_back('{32'h8000_0000, 32'h0, 5'b01000, 32'h0,         1'b0});
`endif
    foreach (v[i]) begin
      A = v[i].a; B = v[i].b; opcode = v[i].op;
      @(posedge clk);
      #1;
      checks++;
      if ({Out, Flag} !== {v[i].eo, v[i].ef}) begin
        failures++;
        $display("FAIL shift[%0d] op=%b got Out=%h Flag=%b expected Out=%h Flag=%b",
                 i, v[i].op, Out, Flag, v[i].eo, v[i].ef);
      end
    end
  endtask

  task automatic test_reset_mid();
    A = 32'h7; B = 32'h9; opcode = 5'b00000;
    @(posedge clk);
    #1;
    checks++;
    if ({Out, Flag} !== {32'h10, 1'b0}) begin
      failures++;
      $display("FAIL reset_mid_pre got Out=%h Flag=%b expected Out=00000010 Flag=0", Out, Flag);
    end
    A = 32'h1; B = 32'h2; opcode = 5'b00000;
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if ({Out, Flag} !== {32'h0, 1'b0}) begin
      failures++;
      $display("FAIL reset_mid_clear got Out=%h Flag=%b expected Out=00000000 Flag=0", Out, Flag);
    end
    @(posedge clk);
    #1;
    checks++;
    if ({Out, Flag} !== {32'h0, 1'b0}) begin
      failures++;
      $display("FAIL reset_mid_hold got Out=%h Flag=%b expected Out=00000000 Flag=0", Out, Flag);
    end
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    checks++;
    if ({Out, Flag} !== {32'h3, 1'b0}) begin
      failures++;
      $display("FAIL reset_mid_release got Out=%h Flag=%b expected Out=00000003 Flag=0", Out, Flag);
    end
  endtask

  // Back-to-back random ops, new operands every cycle, mixing corner values with uniform ones.
  task automatic test_back_to_back();
    logic [31:0] a, b, eo;
    logic [4:0]  op;
    logic        ef;
    int          sel;
    for (int n = 0; n < 400; n++) begin
      sel = int'($urandom_range(0, 3));
      a = (sel == 0) ? 32'hFFFF_FFFF : (sel == 1) ? 32'h0 : $urandom;
      sel = int'($urandom_range(0, 3));
      b = (sel == 0) ? 32'hFFFF_FFFF : (sel == 1) ? 32'h1 : $urandom;
      op = 5'($urandom_range(0, 31));
      model(a, b, op, eo, ef);
      A = a; B = b; opcode = op;
      @(posedge clk);
      #1;
      checks++;
      if ({Out, Flag} !== {eo, ef}) begin
        failures++;
        $display("FAIL random[%0d] op=%b a=%h b=%h got Out=%h Flag=%b expected Out=%h Flag=%b",
                 n, op, a, b, Out, Flag, eo, ef);
      end
    end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_shift();
    test_reset_mid();
    test_back_to_back();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
